// File: rtl/mm2s_sched_pkg.sv
// Shared types and default widths for the MM2S descriptor scheduler.
package mm2s_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT     = 2'd2,
        ST_COMPLETE = 2'd3
    } state_t;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_LEN_W          = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/mm2s_rr_arb.sv
// Round-robin arbiter: searches upward from the slot after ptr, wrapping, and
// returns a one-hot grant (all zero when nothing requests).
module mm2s_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mm2s_sched.sv
// MM2S descriptor scheduler: arbitrates requesters onto a single MM2S engine.
// Optional engine watchdog is enabled with the MM2S_SCHED_TIMEOUT_EN macro.
module mm2s_sched
    import mm2s_sched_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int LEN_W          = DEF_LEN_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        cmp_valid,
    output logic                      cmp_err,
    output logic                      eng_start,
    output logic [ADDR_W-1:0]         eng_addr,
    output logic [LEN_W-1:0]          eng_len,
    input  logic                      eng_done,
    output logic                      eng_abort
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t               state_reg, state_next;
    logic                 err_reg, err_next;
    logic [IDX_W-1:0]     ptr_reg;
    logic [NUM_REQ-1:0]   grant_oh_reg;
    logic [ADDR_W-1:0]    addr_reg;
    logic [LEN_W-1:0]     len_reg;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     grant_idx;
    logic [ADDR_W-1:0]    sel_addr;
    logic [LEN_W-1:0]     sel_len;
    logic [ADDR_W-1:0]    addr_masked [NUM_REQ];
    logic [LEN_W-1:0]     len_masked  [NUM_REQ];
    logic                 handshake;
    logic                 timeout_hit;

    mm2s_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .grant (arb_grant)
    );

    assign req_ready = (state_reg == ST_IDLE) ? arb_grant : '0;
    assign handshake = |(req_valid & req_ready);

    // Mask each requester's descriptor by its grant bit so an OR-reduce selects it.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_sel
            assign addr_masked[gi] = req_addr[gi*ADDR_W +: ADDR_W] & {ADDR_W{arb_grant[gi]}};
            assign len_masked[gi]  = req_len[gi*LEN_W +: LEN_W]    & {LEN_W{arb_grant[gi]}};
        end
    endgenerate

    always_comb begin
        sel_addr  = '0;
        sel_len   = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_addr = sel_addr | addr_masked[i];
            sel_len  = sel_len | len_masked[i];
            if (arb_grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

`ifdef MM2S_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_reg;

    // Counts completed WAIT cycles; cleared whenever WAIT is left or not yet entered.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == ST_WAIT && !eng_done) begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    assign timeout_hit = (state_reg == ST_WAIT) && !eng_done &&
                         (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign eng_abort = timeout_hit;

    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (handshake) begin
                    if (sel_len == '0) begin
                        state_next = ST_COMPLETE;
                        err_next   = 1'b1;
                    end else begin
                        state_next = ST_ISSUE;
                        err_next   = 1'b0;
                    end
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the expiry cycle takes precedence over the abort.
                if (eng_done) begin
                    state_next = ST_COMPLETE;
                    err_next   = 1'b0;
                end else if (timeout_hit) begin
                    state_next = ST_COMPLETE;
                    err_next   = 1'b1;
                end
            end
            ST_COMPLETE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg    <= ST_IDLE;
            err_reg      <= 1'b0;
            ptr_reg      <= IDX_W'(NUM_REQ - 1);
            grant_oh_reg <= '0;
            addr_reg     <= '0;
            len_reg      <= '0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            if (handshake) begin
                ptr_reg      <= grant_idx;
                grant_oh_reg <= arb_grant;
                if (sel_len != '0) begin
                    addr_reg <= sel_addr;
                    len_reg  <= sel_len;
                end
            end
        end
    end

    assign eng_start = (state_reg == ST_ISSUE);
    assign eng_addr  = addr_reg;
    assign eng_len   = len_reg;
    assign cmp_valid = (state_reg == ST_COMPLETE) ? grant_oh_reg : '0;
    assign cmp_err   = (state_reg == ST_COMPLETE) && err_reg;

endmodule

// File: tb/tb_mm2s_sched.sv
// Randomized bench for mm2s_sched against a transaction-timeline reference model.
`timescale 1ns/1ps
module tb_mm2s_sched;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int TO = 16;
`ifdef MM2S_SCHED_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [N-1:0]    cmp_valid;
    logic            cmp_err;
    logic            eng_start;
    logic [AW-1:0]   eng_addr;
    logic [LW-1:0]   eng_len;
    logic            eng_done = 1'b0;
    logic            eng_abort;

    always #5 aclk = ~aclk;

    mm2s_sched #(
        .NUM_REQ        (N),
        .ADDR_W         (AW),
        .LEN_W          (LW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .cmp_valid (cmp_valid),
        .cmp_err   (cmp_err),
        .eng_start (eng_start),
        .eng_addr  (eng_addr),
        .eng_len   (eng_len),
        .eng_done  (eng_done),
        .eng_abort (eng_abort)
    );

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    // Requester-side stimulus state
    bit          d_valid [N];
    logic [AW-1:0] d_addr [N];
    logic [LW-1:0] d_len  [N];
    bit          refill  [N];
    bit          rand_mode = 1'b0;
    bit          force_spur = 1'b0;
    int          fixed_delay = -2;

    // Reference model: one transaction in flight, described by its event cycles
    bit          busy = 1'b0;
    int          owner = 0;
    int          last_grant = N - 1;
    longint      start_cyc = -1;
    longint      cmp_cyc = -1;
    longint      done_cyc = -1;
    bit          exp_err = 1'b0;
    logic [AW-1:0] exp_eaddr = '0;
    logic [LW-1:0] exp_elen = '0;
    logic [AW-1:0] t_addr;
    logic [LW-1:0] t_len;
    int          txn = 0;

    // Observations of the DUT used for scenario-level checks
    int          dut_grants[$];
    int          abort_seen = 0;
    int          cmp_seen = 0;
    int          start_seen = 0;
    bit          last_cmp_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input bit v[N], input int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < N; i++) if (d_valid[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic new_desc(input int i, input bit allow_zero);
        d_addr[i] = $urandom;
        d_len[i]  = (allow_zero && $urandom_range(0, 5) == 0) ? '0 : LW'($urandom_range(1, 4096));
    endtask

    function automatic int pick_delay();
        int r;
        if (fixed_delay != -2) return fixed_delay;
        r = $urandom_range(0, 9);
        if (TMO && r == 0) return TO;
        if (TMO && r == 1) return -1;
        return $urandom_range(1, 20);
    endfunction

    task automatic step();
        int           pick;
        int           dly;
        bit           waiting;
        bit           done;
        bit           exp_abort;
        logic [N-1:0] exp_cmp;
        @(negedge aclk);
        cyc++;
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!d_valid[i] && $urandom_range(0, 3) == 0) begin
                    d_valid[i] = 1'b1;
                    new_desc(i, 1'b1);
                end else if (d_valid[i] && $urandom_range(0, 15) == 0) begin
                    d_valid[i] = 1'b0;
                end
            end
        end
        waiting = busy && start_cyc >= 0 && cmp_cyc < 0 && cyc > start_cyc;
        done = waiting ? (cyc == done_cyc)
                       : (force_spur || (rand_mode && $urandom_range(0, 7) == 0));
        force_spur = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = d_valid[i];
            req_addr[i*AW +: AW]    = d_addr[i];
            req_len[i*LW +: LW]     = d_len[i];
        end
        eng_done = done;
        #1;
        pick      = busy ? -1 : rr_pick(d_valid, last_grant);
        exp_abort = TMO && waiting && !done && (cyc == start_cyc + TO);
        exp_cmp   = (busy && cyc == cmp_cyc) ? (N'(1) << owner) : '0;

        chk("req_ready", 64'(req_ready), (pick < 0) ? 64'd0 : (64'd1 << pick));
        chk("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
        chk("eng_start", 64'(eng_start), 64'(busy && cyc == start_cyc));
        chk("eng_abort", 64'(eng_abort), 64'(exp_abort));
        chk("cmp_valid", 64'(cmp_valid), 64'(exp_cmp));
        if (exp_cmp != '0) chk("cmp_err", 64'(cmp_err), 64'(exp_err));
        else               chk("cmp_err_quiet", 64'(cmp_err), 64'd0);
        chk("eng_addr", 64'(eng_addr), 64'(exp_eaddr));
        chk("eng_len", 64'(eng_len), 64'(exp_elen));

        for (int i = 0; i < N; i++) if (req_ready[i]) dut_grants.push_back(i);
        if (eng_abort) abort_seen++;
        if (eng_start) start_seen++;
        if (cmp_valid != '0) begin
            cmp_seen++;
            last_cmp_err = cmp_err;
        end

        if (waiting) begin
            if (done) begin
                cmp_cyc = cyc + 1;
                exp_err = 1'b0;
            end else if (exp_abort) begin
                cmp_cyc = cyc + 1;
                exp_err = 1'b1;
            end
        end
        if (busy && cyc == cmp_cyc) begin
            busy = 1'b0;
            txn++;
            $display("TXN %0d req=%0d addr=%h len=%0d err=%0b cycle=%0d",
                     txn, owner, t_addr, t_len, exp_err, cyc);
        end else if (pick >= 0) begin
            owner      = pick;
            last_grant = pick;
            busy       = 1'b1;
            t_addr     = d_addr[pick];
            t_len      = d_len[pick];
            if (d_len[pick] == '0) begin
                start_cyc = -1;
                cmp_cyc   = cyc + 1;
                exp_err   = 1'b1;
            end else begin
                start_cyc = cyc + 1;
                cmp_cyc   = -1;
                exp_eaddr = d_addr[pick];
                exp_elen  = d_len[pick];
                dly       = pick_delay();
                done_cyc  = (dly < 0) ? -1 : start_cyc + dly;
            end
            if (refill[pick]) new_desc(pick, 1'b0);
            else              d_valid[pick] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn   = 1'b0;
        for (int i = 0; i < N; i++) d_valid[i] = 1'b0;
        req_valid = '0;
        eng_done  = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_cmp_valid", 64'(cmp_valid), 64'd0);
        chk("rst_cmp_err", 64'(cmp_err), 64'd0);
        chk("rst_eng_start", 64'(eng_start), 64'd0);
        chk("rst_eng_abort", 64'(eng_abort), 64'd0);
        chk("rst_eng_addr", 64'(eng_addr), 64'd0);
        chk("rst_eng_len", 64'(eng_len), 64'd0);
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_hold_cmp_valid", 64'(cmp_valid), 64'd0);
        busy       = 1'b0;
        last_grant = N - 1;
        start_cyc  = -1;
        cmp_cyc    = -1;
        done_cyc   = -1;
        exp_eaddr  = '0;
        exp_elen   = '0;
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic run_until_idle(input int limit, input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((busy || any_pending()) && n < limit);
        chk({tag, "_drained"}, 64'(busy || any_pending()), 64'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            d_valid[i] = 1'b0;
            refill[i]  = 1'b0;
            d_addr[i]  = '0;
            d_len[i]   = '0;
        end
        do_reset();

        // Single unaligned descriptor from r0
        fixed_delay = 3;
        d_valid[0] = 1'b1;
        d_addr[0]  = 32'hC000_0007;
        d_len[0]   = 16'd6;
        start_seen = 0;
        run_until_idle(40, "single");
        chk("single_addr", 64'(eng_addr), 64'hC000_0007);
        chk("single_len", 64'(eng_len), 64'd6);
        chk("single_start_count", 64'(start_seen), 64'd1);
        chk("single_err", 64'(last_cmp_err), 64'd0);

        // r0 and r1 continuously valid after reset: alternating grants
        do_reset();
        dut_grants.delete();
        fixed_delay = 10;
        refill[0] = 1'b1;
        refill[1] = 1'b1;
        new_desc(0, 1'b0);
        new_desc(1, 1'b0);
        d_valid[0] = 1'b1;
        d_valid[1] = 1'b1;
        n = 0;
        while (dut_grants.size() < 4 && n < 200) begin
            step();
            n++;
        end
        refill[0] = 1'b0;
        refill[1] = 1'b0;
        run_until_idle(100, "alternate");
        for (int k = 0; k < 4; k++)
            chk($sformatf("alternate_grant%0d", k),
                64'(dut_grants.size() > k ? dut_grants[k] : -1), 64'(k % 2));

        // Zero-length descriptor from r1
        start_seen = 0;
        cmp_seen   = 0;
        d_valid[1] = 1'b1;
        d_addr[1]  = 32'h0000_1234;
        d_len[1]   = '0;
        run_until_idle(20, "zero_len");
        chk("zero_len_start_count", 64'(start_seen), 64'd0);
        chk("zero_len_cmp_count", 64'(cmp_seen), 64'd1);
        chk("zero_len_err", 64'(last_cmp_err), 64'd1);

`ifdef MM2S_SCHED_TIMEOUT_EN
        // Engine never finishes: watchdog aborts
        abort_seen  = 0;
        fixed_delay = -1;
        d_valid[0] = 1'b1;
        d_addr[0]  = 32'h0000_0100;
        d_len[0]   = 16'd5;
        run_until_idle(60, "timeout");
        chk("timeout_abort_count", 64'(abort_seen), 64'd1);
        chk("timeout_err", 64'(last_cmp_err), 64'd1);
        // Done on the expiry cycle wins
        abort_seen  = 0;
        fixed_delay = TO;
        d_valid[0] = 1'b1;
        run_until_idle(60, "done_at_expiry");
        chk("expiry_abort_count", 64'(abort_seen), 64'd0);
        chk("expiry_err", 64'(last_cmp_err), 64'd0);
`else
        // Without the watchdog WAIT holds until done
        abort_seen  = 0;
        cmp_seen    = 0;
        fixed_delay = -1;
        d_valid[0] = 1'b1;
        d_addr[0]  = 32'h0000_0100;
        d_len[0]   = 16'd5;
        repeat (40) step();
        chk("hold_cmp_count", 64'(cmp_seen), 64'd0);
        done_cyc = cyc + 1;
        run_until_idle(10, "hold_release");
        chk("hold_abort_count", 64'(abort_seen), 64'd0);
        chk("hold_err", 64'(last_cmp_err), 64'd0);
`endif

        // Stray done in IDLE, then reset while a transfer is in WAIT
        cmp_seen   = 0;
        force_spur = 1'b1;
        step();
        chk("stray_done_cmp", 64'(cmp_seen), 64'd0);
        fixed_delay = -1;
        d_valid[1] = 1'b1;
        d_addr[1]  = 32'h0000_0800;
        d_len[1]   = 16'd9;
        n = 0;
        while (!(busy && start_cyc >= 0 && cyc > start_cyc + 2) && n < 20) begin
            step();
            n++;
        end
        chk("mid_wait_cmp", 64'(cmp_seen), 64'd0);
        do_reset();
        dut_grants.delete();
        fixed_delay = 3;
        d_valid[0] = 1'b1;
        d_valid[1] = 1'b1;
        new_desc(0, 1'b0);
        new_desc(1, 1'b0);
        run_until_idle(60, "post_reset");
        chk("post_reset_first_grant", 64'(dut_grants.size() > 0 ? dut_grants[0] : -1), 64'd0);

        // Randomized traffic with random engine latency and stray done pulses
        fixed_delay = -2;
        rand_mode   = 1'b1;
        repeat (1500) step();
        rand_mode = 1'b0;
        run_until_idle(300, "random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
